// File: rtl/history_mem_arbiter.sv
// ============================================================================
// history_mem_arbiter : shares the color-history SRAM between pixel reads,
// buffered write-backs with read forwarding, and a full-memory clear. rev 1.0
// ============================================================================
`default_nettype none

module history_mem_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 307200,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [2:0]        wb_count,
  output logic              overflow_err,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                c_PTR_W = $clog2(WB_DEPTH);
  localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        c_FULL  = 3'(WB_DEPTH);

  typedef enum logic [0:0] {ST_NORMAL = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [c_PTR_W-1:0]  head_q, tail_q;
  logic [2:0]          count_q;
  logic                ovf_q, done_q;
  logic                rd_valid_q, rd_clr_q, fwd_hit_q;
  logic [DATA_W-1:0]   fwd_data_q;

  logic [ADDR_W-1:0]   fifo_addr_q [WB_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [WB_DEPTH];

  logic                normal, pop, push, drop, full_after_pop;
  logic [2:0]          count_after_pop;
  logic                fwd_hit_d;
  logic [DATA_W-1:0]   fwd_data_d;
  logic [c_PTR_W-1:0]  fwd_idx;

  assign normal          = (state_q == ST_NORMAL);
  assign pop             = normal && !rd_req && (count_q != 3'd0);
  assign count_after_pop = count_q - {2'b00, pop};
  assign full_after_pop  = (count_after_pop == c_FULL);
  assign push            = normal && wb_we && !clear_req && !full_after_pop;
  assign drop            = normal && wb_we && !clear_req && full_after_pop;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit_d  = 1'b0;
    fwd_data_d = '0;
    fwd_idx    = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      fwd_idx = head_q + c_PTR_W'(i);
      if ((3'(i) < count_q) && (fifo_addr_q[fwd_idx] == rd_addr)) begin
        fwd_hit_d  = 1'b1;
        fwd_data_d = fifo_data_q[fwd_idx];
      end
    end
  end

  // Memory port is driven straight from this cycle's grant; held quiet in reset.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we   = 1'b1;
        mem_addr = cnt_q;
      end else if (rd_req) begin
        mem_addr = rd_addr;
      end else if (pop) begin
        mem_we    = 1'b1;
        mem_addr  = fifo_addr_q[head_q];
        mem_wdata = fifo_data_q[head_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[tail_q] <= wb_addr;
      fifo_data_q[tail_q] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_NORMAL;
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_clr_q   <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      rd_valid_q <= rd_req;
      rd_clr_q   <= !normal;
      fwd_hit_q  <= rd_req && normal && fwd_hit_d;
      fwd_data_q <= fwd_data_d;
      done_q     <= 1'b0;
      if (clear_req) begin
        state_q <= ST_CLEAR;
        cnt_q   <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (state_q == ST_CLEAR) begin
        if (cnt_q == c_LAST) begin
          state_q <= ST_NORMAL;
          cnt_q   <= '0;
          done_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        if (pop)  head_q <= head_q + 1'b1;
        if (push) tail_q <= tail_q + 1'b1;
        count_q <= count_after_pop + {2'b00, push};
        if (drop) ovf_q <= 1'b1;
      end
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_data      = (!rd_valid_q || rd_clr_q) ? '0 :
                        (fwd_hit_q ? fwd_data_q : mem_rdata);
  assign wb_count     = count_q;
  assign overflow_err = ovf_q;
  assign clear_busy   = (state_q == ST_CLEAR);
  assign clear_done   = done_q;

endmodule

`default_nettype wire

// File: doc/history_mem_arbiter.md
Name: history_mem_arbiter

Overview:
- Shares the single-port color-history SRAM (one 4-bit history word per pixel, 640x480) among three requesters:
  - the pixel read stream feeding corner detection;
  - the corner detector's write-backs of updated history;
  - a frame-clear engine that wipes the whole memory.
- Sits between the VGA-scan address generator, the corner detector and the M10K history RAM.
- Reads are never stalled. Write-backs are buffered in a small FIFO and drained in idle slots. Read-after-write hazards are resolved by forwarding from the FIFO.

Parameters:
- ADDR_W, 19, memory address width.
- DATA_W, 4, history word width.
- DEPTH, 307200, number of words swept by a clear.
- WB_DEPTH, 4, write-back FIFO entries (power of 2, at least 2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rd_req  in  1  pixel read request this cycle
- rd_addr  in  ADDR_W  read address
- rd_valid  out  1  read data valid (1 cycle after rd_req)
- rd_data  out  DATA_W  read data
- wb_we  in  1  write-back request
- wb_addr  in  ADDR_W  write-back address
- wb_data  in  DATA_W  write-back data
- wb_count  out  3  FIFO occupancy (0..WB_DEPTH)
- overflow_err  out  1  sticky: a write-back was dropped
- clear_req  in  1  single-cycle pulse: start a memory clear
- clear_busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse when the clear finishes
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; registered RAM, valid the cycle after the address

Behaviour:
- Reset (async): FSM=NORMAL; FIFO empty; clear counter=0. Outputs: rd_valid=0, rd_data=0, wb_count=0, overflow_err=0, clear_busy=0, clear_done=0, mem_we=0, mem_addr=0, mem_wdata=0.
- FSM has two states: NORMAL and CLEAR.
- NORMAL, port grant each cycle (memory outputs combinational from grant):
  - rd_req=1: mem_addr=rd_addr, mem_we=0.
  - else if FIFO non-empty: pop head; mem_addr/mem_wdata=head; mem_we=1.
  - else mem_we=0.
- Read latency is exactly 1: rd_valid is the registered rd_req. rd_data comes from forwarding or mem_rdata.
- Forwarding:
  - At rd_req, rd_addr is compared against all valid FIFO entries, as they stand before this cycle's push. This cycle's pop is excluded from the compare; it is not written because a read wins.
  - On a match, the youngest matching entry's data is registered and presented as rd_data next cycle. Otherwise rd_data=mem_rdata.
  - A wb_we with the same address arriving in the same cycle as rd_req is NOT forwarded.
- FIFO push:
  - wb_we=1 and FIFO not full (after this cycle's pop): push.
  - wb_we=1 and full: drop the write, set overflow_err.
  - Push and pop in the same cycle are allowed; wb_count is unchanged.
- overflow_err clears only on reset or clear_req.
- Entering CLEAR: clear_req=1 from any state → next state CLEAR. Counter=0, FIFO flushed (wb_count=0), overflow_err=0, clear_busy=1.
- CLEAR state:
  - mem_we=1, mem_addr=counter, mem_wdata=0; counter increments each cycle.
  - The cycle with counter=DEPTH-1 is the last write; then FSM→NORMAL, clear_busy=0, clear_done=1 for 1 cycle.
  - A clear takes exactly DEPTH cycles.
  - rd_req is still answered with 1-cycle latency: rd_valid=1, rd_data=0, no RAM read.
  - wb_we is discarded silently; overflow_err does not set.
  - clear_req while in CLEAR restarts the counter at 0.
- Counter arithmetic: ADDR_W bits, compare against DEPTH-1; never wraps past DEPTH-1.
- Reset mid-clear: immediate abort to the reset state. Memory contents are partially cleared (not repaired).

Test Plan:
- Reset and idle: assert reset mid-operation → all outputs 0 immediately (async); after release, mem_we=0 and wb_count=0.
- Read latency: rd_req with rd_addr=0x00123 and RAM holding 4'b1010 → next cycle rd_valid=1, rd_data=4'b1010, mem_we=0 during the request cycle.
- Write drain: 3 write-backs (addr 5, 6, 7; data 1, 2, 3) with rd_req=0 → mem_we on 3 consecutive cycles in order; wb_count goes 1,1,1 then 0.
- Forwarding and priority:
  - Push (addr 9, data 4'b0111), then rd_req to addr 9 every cycle → rd_data=4'b0111 via forwarding; write stays queued (mem_we=0).
  - Push a second entry (addr 9, data 4'b0001) → reads return 4'b0001 (youngest).
- Overflow: hold rd_req=1 and issue 5 consecutive wb_we → wb_count=4, fifth write dropped, overflow_err=1; clear_req clears it.
- Clear:
  - clear_req → clear_busy=1; mem_addr runs 0..307199 with mem_wdata=0 and mem_we=1; clear_done pulses after exactly 307200 write cycles.
  - rd_req during the clear returns rd_data=0.
  - wb_we during the clear → wb_count stays 0.
  - clear_req at counter=1000 → counter restarts at 0.
